// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: lets two requesters share one 7x7-IFM / 3x3-kernel
// convolution engine, one job at a time.
// A job is granted, then the owner's IFM/weight words are streamed into the
// engine through registers. The engine's OFM words come back tagged with the
// owner ID. A fixed cool-down separates consecutive jobs.
// Optional feature macro: SCHED_RR_EN. When it is defined, round-robin
// arbitration is used. When it is undefined, requester 0 wins every tie.
// The FSM state is held in state_q (type state_e) so it can be probed.
//
// Handshake semantics: there is no back-pressure anywhere.
// - gnt_<n> is high for exactly IFM_LEN consecutive cycles. On each of those
//   cycles the owner must present a valid ifm_<n>. During the first KER_LEN
//   of those cycles it must also present a valid w_<n>.
// - eng_in_valid / eng_weight_valid qualify eng_ifm / eng_weight on every
//   cycle they are high.
// - eng_out_valid qualifies eng_ofm on the cycle it is high.
// - res_valid qualifies res_data / res_id / res_last for one cycle. The
//   consumer must accept the word on that cycle.
module conv_job_scheduler #(
  parameter int IFM_LEN = 49,
  parameter int KER_LEN = 9,
  parameter int OUT_LEN = 25,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_0,
  input  logic        req_1,
  output logic        gnt_0,
  output logic        gnt_1,
  input  logic [15:0] ifm_0,
  input  logic [15:0] w_0,
  input  logic [15:0] ifm_1,
  input  logic [15:0] w_1,
  output logic        eng_in_valid,
  output logic        eng_weight_valid,
  output logic [15:0] eng_ifm,
  output logic [15:0] eng_weight,
  input  logic        eng_out_valid,
  input  logic [35:0] eng_ofm,
  output logic        res_valid,
  output logic [35:0] res_data,
  output logic        res_id,
  output logic        res_last,
  output logic        busy,
  output logic        err_timeout
);

  localparam int S_W = (IFM_LEN > 1) ? $clog2(IFM_LEN) : 1;
  localparam int R_W = $clog2(OUT_LEN + 1);
  localparam int T_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int C_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_OUT = 2'd2,
    ST_COOL     = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic [S_W-1:0] s_q, s_d;   // stream position within the job
  logic [R_W-1:0] r_q, r_d;   // results accepted for the job
  logic [T_W-1:0] t_q, t_d;   // cycles spent in WAIT_OUT
  logic [C_W-1:0] c_q, c_d;   // cool-down cycles elapsed

  logic        eng_in_valid_q, eng_in_valid_d;
  logic        eng_weight_valid_q, eng_weight_valid_d;
  logic [15:0] eng_ifm_q, eng_ifm_d;
  logic [15:0] eng_weight_q, eng_weight_d;
  logic        res_valid_q, res_valid_d;
  logic [35:0] res_data_q, res_data_d;
  logic        res_id_q, res_id_d;
  logic        res_last_q, res_last_d;
  logic        err_q, err_d;

  logic        streaming;
  logic        count_en;
  logic        pick_owner;

`ifdef SCHED_RR_EN
  // Last requester served. Its reset value of 1 gives requester 0 the first tie.
  logic last_q, last_d;

  // Round-robin: on a tie, the requester served last loses. A lone requester always wins.
  always_comb begin
    pick_owner = 1'b0;
    if (req_0 && req_1) pick_owner = ~last_q;
    else                pick_owner = ~req_0;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  // Fixed priority: requester 0 wins whenever it asks.
  always_comb begin
    pick_owner = ~req_0;
  end
`endif

  assign streaming = (state_q == ST_STREAM);
  // Results are accepted while streaming as well, because the engine starts
  // producing before its input stream ends.
  assign count_en  = eng_out_valid && (r_q < R_W'(OUT_LEN)) &&
                     ((state_q == ST_STREAM) || (state_q == ST_WAIT_OUT));

  // Next-state, counters, and registered engine/result drive.
  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    s_d                = s_q;
    r_d                = r_q;
    t_d                = t_q;
    c_d                = c_q;
    err_d              = 1'b0;
    res_valid_d        = 1'b0;
    res_data_d         = '0;
    res_id_d           = 1'b0;
    res_last_d         = 1'b0;
`ifdef SCHED_RR_EN
    last_d             = last_q;
`endif
    eng_in_valid_d     = streaming;
    eng_weight_valid_d = streaming && (s_q < S_W'(KER_LEN));
    eng_ifm_d          = streaming ? (owner_q ? ifm_1 : ifm_0) : 16'd0;
    eng_weight_d       = eng_weight_valid_d ? (owner_q ? w_1 : w_0) : 16'd0;

    if (count_en) begin
      res_valid_d = 1'b1;
      res_data_d  = eng_ofm;
      res_id_d    = owner_q;
      res_last_d  = (r_q == R_W'(OUT_LEN - 1));
      r_d         = r_q + R_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (req_0 || req_1) begin
          state_d = ST_STREAM;
          owner_d = pick_owner;
          s_d     = '0;
          r_d     = '0;
          t_d     = '0;
          c_d     = '0;
`ifdef SCHED_RR_EN
          last_d  = pick_owner;
`endif
        end
      end
      ST_STREAM: begin
        // A requester dropping its req here is ignored: the grant is committed.
        if (s_q == S_W'(IFM_LEN - 1)) begin
          state_d = ST_WAIT_OUT;
          t_d     = '0;
        end else begin
          s_d = s_q + S_W'(1);
        end
      end
      ST_WAIT_OUT: begin
        if (r_d == R_W'(OUT_LEN)) begin
          state_d = ST_COOL;
          c_d     = '0;
        end else if (t_q == T_W'(TIMEOUT - 1)) begin
          state_d = ST_COOL;
          c_d     = '0;
          err_d   = 1'b1;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      ST_COOL: begin
        if (c_q == C_W'(GAP - 1)) state_d = ST_IDLE;
        else                      c_d = c_q + C_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, owner and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      t_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      s_q     <= s_d;
      r_q     <= r_d;
      t_q     <= t_d;
      c_q     <= c_d;
    end
  end

  // Engine-side and result-side output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_in_valid_q     <= 1'b0;
      eng_weight_valid_q <= 1'b0;
      eng_ifm_q          <= '0;
      eng_weight_q       <= '0;
      res_valid_q        <= 1'b0;
      res_data_q         <= '0;
      res_id_q           <= 1'b0;
      res_last_q         <= 1'b0;
      err_q              <= 1'b0;
    end else begin
      eng_in_valid_q     <= eng_in_valid_d;
      eng_weight_valid_q <= eng_weight_valid_d;
      eng_ifm_q          <= eng_ifm_d;
      eng_weight_q       <= eng_weight_d;
      res_valid_q        <= res_valid_d;
      res_data_q         <= res_data_d;
      res_id_q           <= res_id_d;
      res_last_q         <= res_last_d;
      err_q              <= err_d;
    end
  end

  assign gnt_0            = streaming && !owner_q;
  assign gnt_1            = streaming &&  owner_q;
  assign busy             = (state_q != ST_IDLE);
  assign eng_in_valid     = eng_in_valid_q;
  assign eng_weight_valid = eng_weight_valid_q;
  assign eng_ifm          = eng_ifm_q;
  assign eng_weight       = eng_weight_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;
  assign res_id           = res_id_q;
  assign res_last         = res_last_q;
  assign err_timeout      = err_q;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Testbench for conv_job_scheduler.
// Expected results come from a job-level reference model. The model works
// from offsets relative to the first grant cycle:
// - grant on offsets 0..48;
// - engine inputs on offsets 1..49;
// - results accepted until the 25th result or the timeout at offset 112;
// - cool-down of 4 cycles, then idle.
// Round-robin expectations are selected with SCHED_RR_EN.
module tb_conv_job_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_0, req_1;
  logic        gnt_0, gnt_1;
  logic [15:0] ifm_0, w_0, ifm_1, w_1;
  logic        eng_in_valid, eng_weight_valid;
  logic [15:0] eng_ifm, eng_weight;
  logic        eng_out_valid;
  logic [35:0] eng_ofm;
  logic        res_valid;
  logic [35:0] res_data;
  logic        res_id, res_last;
  logic        busy, err_timeout;

  conv_job_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1),
    .ifm_0(ifm_0), .w_0(w_0), .ifm_1(ifm_1), .w_1(w_1),
    .eng_in_valid(eng_in_valid), .eng_weight_valid(eng_weight_valid),
    .eng_ifm(eng_ifm), .eng_weight(eng_weight),
    .eng_out_valid(eng_out_valid), .eng_ofm(eng_ofm),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_last(res_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int last_served = 1;

  // Per-job stimulus.
  logic [15:0] ifm_a [0:48];
  logic [15:0] w_a   [0:48];
  bit          ov_a  [0:159];
  logic [35:0] ofm_a [0:159];

  // Scoreboard: expected {last, id, data} and the offset where each result is due.
  logic [37:0] exp_q[$];
  int          exp_t_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input bit r0, input bit r1, input int last);
`ifdef SCHED_RR_EN
    if (r0 && r1) return (last == 0) ? 1 : 0;
`endif
    return r0 ? 0 : 1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    ifm_0 = '0; w_0 = '0; ifm_1 = '0; w_1 = '0;
    eng_out_valid = 1'b0; eng_ofm = '0;
    last_served = 1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Build one job's stimulus: IFM/weight words plus an engine output schedule.
  task automatic gen_job(input bit ramp, input int n_out, input int n_extra);
    int p;
    for (int k = 0; k < 49; k++) begin
      ifm_a[k] = ramp ? 16'(k)     : 16'($urandom);
      w_a[k]   = ramp ? 16'(k + 1) : 16'($urandom);
    end
    for (int k = 0; k < 160; k++) begin
      ov_a[k]  = 1'b0;
      ofm_a[k] = {4'($urandom), 32'($urandom)};
    end
    p = $urandom_range(30, 10);
    for (int i = 0; i < n_out; i++) begin
      ov_a[p] = 1'b1;
      p += $urandom_range(3, 1);
    end
    for (int i = 0; i < n_extra; i++) ov_a[$urandom_range(159, p)] = 1'b1;
  endtask

  // Drive one job and check every cycle from the first grant to the return to idle.
  // Called while the DUT is idle. The request lines must already be set.
  task automatic run_job(input int exp_owner, input int drop_at);
    int cnt, cool_start, waited, last_o;
    bit timed_out, g, ev, wv, exp_present;
    logic [37:0] exp_vec, got_vec, e, got;
    cnt = 0; cool_start = 113; timed_out = 1'b1;
    exp_q.delete(); exp_t_q.delete();
    for (int p = 0; p <= 112; p++) begin
      if (ov_a[p] && cnt < 25) begin
        exp_q.push_back({cnt == 24, exp_owner[0], ofm_a[p]});
        exp_t_q.push_back(p + 1);
        cnt++;
        if (cnt == 25) begin
          cool_start = (p + 1 > 50) ? p + 1 : 50;
          timed_out = 1'b0;
          break;
        end
      end
    end
    last_o = cool_start + 4;

    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(gnt_0 || gnt_1) && waited < 8);
    total++;
    if (waited !== 1) begin
      fails++;
      $display("FAIL grant_latency: got %0d cycles, expected 1", waited);
    end else passed++;
    total++;
    if ({gnt_1, gnt_0} !== (exp_owner == 1 ? 2'b10 : 2'b01)) begin
      fails++;
      $display("FAIL grant_owner: gnt_1/gnt_0=%b%b, expected owner %0d", gnt_1, gnt_0, exp_owner);
    end else passed++;
    last_served = exp_owner;

    for (int o = 0; o <= last_o; o++) begin
      ifm_0 = 16'($urandom); w_0 = 16'($urandom);
      ifm_1 = 16'($urandom); w_1 = 16'($urandom);
      if (o < 49) begin
        if (exp_owner == 0) begin ifm_0 = ifm_a[o]; w_0 = w_a[o]; end
        else                begin ifm_1 = ifm_a[o]; w_1 = w_a[o]; end
      end
      if (o == drop_at) begin req_0 = 1'b0; req_1 = 1'b0; end
      eng_out_valid = ov_a[o];
      eng_ofm       = ofm_a[o];

      g  = (o < 49);
      ev = (o >= 1 && o <= 49);
      wv = (o >= 1 && o <= 9);
      exp_vec = {g && exp_owner == 0, g && exp_owner == 1, o < cool_start + 4,
                 timed_out && o == 113, ev, wv,
                 ev ? ifm_a[ev ? o - 1 : 0] : 16'd0,
                 wv ? w_a[wv ? o - 1 : 0] : 16'd0};
      got_vec = {gnt_0, gnt_1, busy, err_timeout, eng_in_valid, eng_weight_valid,
                 eng_ifm, eng_weight};
      total++;
      if (got_vec !== exp_vec) begin
        fails++;
        $display("FAIL ctrl_vec offset %0d: got %h, expected %h", o, got_vec, exp_vec);
      end else passed++;

      exp_present = (exp_t_q.size() > 0) && (exp_t_q[0] == o);
      total++;
      if (res_valid !== exp_present) begin
        fails++;
        $display("FAIL res_valid offset %0d: got %b, expected %b", o, res_valid, exp_present);
      end else passed++;
      if (exp_present) begin
        e = exp_q.pop_front();
        void'(exp_t_q.pop_front());
        got = {res_last, res_id, res_data};
        total++;
        if (got !== e) begin
          fails++;
          $display("FAIL res_word offset %0d: got %h, expected %h", o, got, e);
        end else passed++;
      end
      if (o < last_o) tick();
    end
    eng_out_valid = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL results_drained: %0d results missing, expected 0", exp_q.size());
    end else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    ifm_0 = '0; w_0 = '0; ifm_1 = '0; w_1 = '0;
    eng_out_valid = 1'b0; eng_ofm = '0;
    #2;
    total++;
    if ({gnt_0, gnt_1, busy, err_timeout, eng_in_valid, eng_weight_valid, eng_ifm, eng_weight,
         res_valid, res_data, res_id, res_last} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: some output nonzero during reset");
    end else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({gnt_0, gnt_1, busy, res_valid, err_timeout} !== 5'b0) begin
      fails++;
      $display("FAIL reset_idle: got %b, expected 00000", {gnt_0, gnt_1, busy, res_valid, err_timeout});
    end else passed++;
  endtask

  task automatic test_spurious();
    req_0 = 1'b0; req_1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eng_out_valid = 1'b1;
      eng_ofm = {4'($urandom), 32'($urandom)};
      tick();
      total++;
      if ({res_valid, busy, gnt_0, gnt_1} !== 4'b0) begin
        fails++;
        $display("FAIL spurious_idle: got %b, expected 0000", {res_valid, busy, gnt_0, gnt_1});
      end else passed++;
    end
    eng_out_valid = 1'b0;
    tick();
    total++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL spurious_res: res_valid=%b, expected 0", res_valid);
    end else passed++;
  endtask

  task automatic test_single_job();
    req_0 = 1'b1; req_1 = 1'b0;
    gen_job(1'b1, 25, 0);
    run_job(pick(1'b1, 1'b0, last_served), 49);
  endtask

  task automatic test_back_to_back();
    int own;
    do_reset();
    req_0 = 1'b1; req_1 = 1'b1;
    own = pick(1'b1, 1'b1, last_served);
    gen_job(1'b0, 25, 3);
    run_job(own, -1);
    own = pick(1'b1, 1'b1, last_served);
    gen_job(1'b0, 27, 2);
    run_job(own, 60);
  endtask

  task automatic test_timeout();
    req_0 = 1'b0; req_1 = 1'b1;
    gen_job(1'b0, 20, 0);
    run_job(1, -1);
    gen_job(1'b0, 25, 0);
    run_job(1, 49);
  endtask

  task automatic test_req_drop();
    req_0 = 1'b1; req_1 = 1'b0;
    gen_job(1'b0, 25, 1);
    run_job(0, 10);
  endtask

  task automatic test_reset_mid_stream();
    int waited;
    req_0 = 1'b1; req_1 = 1'b0;
    gen_job(1'b1, 25, 0);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!gnt_0 && waited < 8);
    for (int o = 0; o <= 20; o++) begin
      ifm_0 = ifm_a[o]; w_0 = w_a[o];
      if (o < 20) tick();
    end
    total++;
    if (gnt_0 !== 1'b1) begin
      fails++;
      $display("FAIL gnt_before_reset: gnt_0=%b, expected 1", gnt_0);
    end else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({gnt_0, gnt_1, busy, err_timeout, eng_in_valid, eng_weight_valid, eng_ifm, eng_weight,
         res_valid, res_data, res_id, res_last} !== '0) begin
      fails++;
      $display("FAIL reset_mid_stream: some output nonzero after reset assertion");
    end else passed++;
    req_0 = 1'b0; req_1 = 1'b1;
    last_served = 1;
    tick(); tick();
    rst_n = 1'b1;
    gen_job(1'b0, 25, 0);
    run_job(1, 49);
  endtask

  task automatic test_random();
    bit r0, r1;
    int n;
    for (int j = 0; j < 4; j++) begin
      r0 = 1'($urandom_range(1, 0));
      r1 = r0 ? 1'($urandom_range(1, 0)) : 1'b1;
      req_0 = r0; req_1 = r1;
      n = (j == 2) ? 20 : 25 + $urandom_range(2, 0);
      gen_job(1'b0, n, (n >= 25) ? $urandom_range(3, 0) : 0);
      run_job(pick(r0, r1, last_served), (j == 3) ? 55 : -1);
    end
  endtask

  initial begin
    test_reset();
    test_spurious();
    test_single_job();
    test_back_to_back();
    test_timeout();
    test_req_drop();
    test_reset_mid_stream();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv_job_scheduler.md
Name: conv_job_scheduler

Overview:
- Sequences and shares one 7x7-IFM / 3x3-kernel convolution engine between two requesters.
- Grants one requester at a time and streams that requester's IFM and weight words into the engine with registered in_valid/weight_valid.
- Counts the engine's OFM outputs and returns them tagged with the owner ID, then enforces a cool-down so the engine returns to idle before the next job.

Parameters:
- IFM_LEN, 49, IFM words per job (7x7).
- KER_LEN, 9, weight words per job, sent on the first KER_LEN stream cycles.
- OUT_LEN, 25, OFM results expected per job (5x5).
- GAP, 4, cool-down cycles after a job before the next grant.
- TIMEOUT, 64, max cycles in WAIT_OUT before the job is aborted.

Ports:
- clk  in  1  clock, all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_0  in  1  requester 0 job request (level).
- req_1  in  1  requester 1 job request (level).
- gnt_0  out  1  high for exactly IFM_LEN consecutive cycles while requester 0 streams.
- gnt_1  out  1  same, for requester 1.
- ifm_0  in  16  requester 0 IFM word, valid when gnt_0 is high.
- w_0  in  16  requester 0 weight word, valid on the first KER_LEN gnt_0 cycles.
- ifm_1  in  16  requester 1 IFM word.
- w_1  in  16  requester 1 weight word.
- eng_in_valid  out  1  to engine in_valid.
- eng_weight_valid  out  1  to engine weight_valid.
- eng_ifm  out  16  to engine In_IFM_1.
- eng_weight  out  16  to engine In_Weight_1.
- eng_out_valid  in  1  from engine out_valid.
- eng_ofm  in  36  from engine Out_OFM.
- res_valid  out  1  result word valid.
- res_data  out  36  result word.
- res_id  out  1  owner of the result (0/1).
- res_last  out  1  high with the OUT_LEN-th result of a job.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  one-cycle pulse on job abort.

Behaviour:
- Reset: all outputs 0, state IDLE, owner 0, counters 0, RR pointer favours requester 0. Reset may arrive mid-job: the job is dropped and the next job starts cleanly from IDLE.
- States: IDLE, STREAM, WAIT_OUT, COOL.
- IDLE: if any req is high, choose an owner by the arbitration rule and go to STREAM next cycle. Otherwise stay in IDLE.
- STREAM: gnt_<owner> is high while the stream counter s runs 0..IFM_LEN-1.
  - At s=IFM_LEN-1, go to WAIT_OUT.
  - Dropping req during STREAM is ignored; the grant is committed.
  - gnt is combinational from state and owner.
- Engine drive: all four engine signals are registered from the owner's inputs, one cycle after the gnt cycle.
  - eng_in_valid = 1 for every gnt cycle.
  - eng_weight_valid = 1 when s < KER_LEN.
  - eng_weight = 0 when eng_weight_valid = 0.
  - Outside streaming, all four engine signals are 0.
- Output counting: the engine emits results while inputs are still streaming, so eng_out_valid is counted in both STREAM and WAIT_OUT (result counter r, 0..OUT_LEN).
- Result path: each counted eng_out_valid produces a registered res_valid=1 next cycle, with res_data=eng_ofm and res_id=owner.
  - res_last=1 on the result where r reaches OUT_LEN.
  - eng_out_valid in IDLE or COOL, or after r=OUT_LEN, is dropped with no res_valid.
- WAIT_OUT:
  - r=OUT_LEN (counting the current cycle's eng_out_valid) → COOL.
  - Otherwise, the timeout counter reaching TIMEOUT-1 → err_timeout pulse and go to COOL; res_last is never asserted for that job.
- COOL: wait GAP cycles, then go to IDLE. req is not sampled in COOL.
- Back-to-back: a held req is re-granted after COOL, subject to arbitration.
- Arbitration (default): fixed priority, requester 0 wins when both request.

Optional Feature:
- Macro: SCHED_RR_EN.
- Defined: round-robin arbitration. The requester served last has lowest priority when both request; the pointer updates on entry to STREAM; a single requester is always granted.
- Undefined: fixed priority, requester 0 always wins ties; requester 1 can starve.

Test Plan:
- Single job: req_0=1, ifm_0=k and w_0=k+1 on stream cycle k.
  - gnt_0 high for 49 cycles; eng_weight_valid high 9 cycles with weights 1..9; eng_ifm 0..48, each lagging gnt by one cycle.
  - 25 res_valid with res_id=0; res_last on the 25th; then COOL for 4 cycles and IDLE.
- Simultaneous requests: req_0=req_1=1 held across two jobs.
  - Without SCHED_RR_EN: grants 0 then 0.
  - With SCHED_RR_EN: grants 0 then 1.
- Timeout: engine model returns only 20 outputs.
  - err_timeout pulses exactly once, 64 cycles after WAIT_OUT entry; no res_last; next grant follows after 4 cool-down cycles.
- Spurious output: eng_out_valid=1 while in IDLE → no res_valid, state unchanged.
- Reset mid-stream: rst_n=0 at s=20 → all outputs 0 immediately. After release, req_1 alone is granted from s=0 and gets the full 49-cycle stream.
- req drop: req_0 deasserted at s=10 → gnt_0 still completes 49 cycles and all 25 results return.
